// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID opcode into the control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB. It also detects load-use hazards (stall)
// and kills the ID instruction on a taken branch (flush).
// Optional feature: define CTRL_PERF_EN to add saturating stall/flush counters.
module pipe_ctrl_unit #(
  parameter int unsigned OPC_W      = 6,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPC_W-1:0]      id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_flush,
  output logic                  stall_out,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic                  ex_alusrc,
  output logic                  ex_isbranch,
  output logic                  ex_isjump,
  output logic                  ex_ill_op,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  wb_regwrite,
  output logic                  wb_mem2reg
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);

  typedef struct packed {
    logic                  valid;
    logic [ALUOP_W-1:0]    aluop;
    logic                  alusrc;
    logic                  isbranch;
    logic                  isjump;
    logic                  ill_op;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic                  mem2reg;
    logic [REG_ADDR_W-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic valid;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic mem2reg;
  } exmem_t;

  // WB is the last stage, so it only keeps the controls it drives.
  typedef struct packed {
    logic regwrite;
    logic mem2reg;
  } memwb_t;

  idex_t  dec;
  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   uses_rt;

  // ID-stage decode of the opcode into the full control bundle.
  always_comb begin
    dec       = '0;
    uses_rt   = 1'b0;
    dec.valid = 1'b1;
    dec.rt    = id_rt;
    case (id_opcode)
      OP_RTYPE: begin
        dec.aluop[1]  = 1'b1;
        dec.regwrite  = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        dec.alusrc    = 1'b1;
        dec.regwrite  = 1'b1;
        dec.mem2reg   = 1'b1;
        dec.memread   = 1'b1;
      end
      OP_SW: begin
        dec.alusrc    = 1'b1;
        dec.memwrite  = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.aluop[0]  = 1'b1;
        dec.isbranch  = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_J: begin
        dec.isjump    = 1'b1;
      end
      OP_ADDI: begin
        dec.alusrc    = 1'b1;
        dec.regwrite  = 1'b1;
        if (ALUOP_W > 2) dec.aluop[ALUOP_W-1] = 1'b1;
      end
      default: begin
        dec.ill_op    = 1'b1;
      end
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    stall_out = id_valid & idex_q.valid & idex_q.memread &
                (idex_q.rt != '0) &
                ((idex_q.rt == id_rs) | ((idex_q.rt == id_rt) & uses_rt)) &
                ~ex_flush;
  end

  // Next-state of the stage registers: bubble into EX on stall, flush or empty ID.
  always_comb begin
    idex_d = (id_valid & ~stall_out & ~ex_flush) ? dec : '0;

    exmem_d          = '0;
    exmem_d.valid    = idex_q.valid;
    exmem_d.memread  = idex_q.valid & idex_q.memread;
    exmem_d.memwrite = idex_q.valid & idex_q.memwrite;
    exmem_d.regwrite = idex_q.valid & idex_q.regwrite;
    exmem_d.mem2reg  = idex_q.valid & idex_q.mem2reg;

    memwb_d          = '0;
    memwb_d.regwrite = exmem_q.valid & exmem_q.regwrite;
    memwb_d.mem2reg  = exmem_q.valid & exmem_q.mem2reg;
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_aluop     = idex_q.aluop;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_isbranch  = idex_q.isbranch;
  assign ex_isjump    = idex_q.isjump;
  assign ex_ill_op    = idex_q.ill_op;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_mem2reg   = memwb_q.mem2reg;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q;
  logic [CNT_W-1:0] perf_flush_q;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_out && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (ex_flush && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  // Counter width only matters when the counters are built.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W'(0);
`endif

endmodule
